// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter sharing one registered FIFO write port among NUM_REQ pixel fetchers.
// Define ARB_WATCHDOG_EN to add the stall watchdog and its sticky wd_flag output.
module fifo_rr_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int ID_W       = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [CNT_W-1:0]          fifo_count,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                      wd_flag
`endif
);

  localparam int BEAT_W = 5;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_r;
  state_t             state_s;
  logic [BEAT_W-1:0]  beat_cnt_r;
  logic [ID_W-1:0]    winner_s;
  logic               found_s;
  logic [CNT_W:0]     occ_s;
  logic               space_ok_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic [DATA_W-1:0]  g_data_s;
  logic               acc_s;
  logic               end_s;
  logic               wd_fire_s;

  // Granted requester's valid/last/data, plus space check including the write in flight
  always_comb begin
    g_valid_s = req_valid[grant_id];
    g_last_s  = req_last[grant_id];
    g_data_s  = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      g_data_s = (grant_id == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : g_data_s;
    end
    occ_s      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr};
    space_ok_s = (occ_s < (CNT_W+1)'(FIFO_DEPTH));
    acc_s      = (state_r == BURST) && g_valid_s && space_ok_s && !rst;
    end_s      = acc_s && (g_last_s || (beat_cnt_r == BEAT_W'(BURST_LEN - 1)));
  end

  // Round-robin scan starting one past the last winner
  always_comb begin
    found_s  = 1'b0;
    winner_s = grant_id;
    for (int i = 1; i <= NUM_REQ; i++) begin
      winner_s = (!found_s && req_valid[ID_W'((int'(grant_id) + i) % NUM_REQ)])
                 ? ID_W'((int'(grant_id) + i) % NUM_REQ) : winner_s;
      found_s  = found_s | req_valid[ID_W'((int'(grant_id) + i) % NUM_REQ)];
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt_r;

  assign wd_fire_s = (state_r == BURST) && !g_valid_s &&
                     (stall_cnt_r == STALL_W'(TIMEOUT - 1));

  // Stall counter counts only cycles where the grantee is not valid; space stalls hold it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {STALL_W{1'b0}};
      wd_flag     <= 1'b0;
    end else begin
      if (state_r != BURST || acc_s || wd_fire_s) begin
        stall_cnt_r <= {STALL_W{1'b0}};
      end else if (!g_valid_s) begin
        stall_cnt_r <= stall_cnt_r + STALL_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      wd_flag <= wd_flag | wd_fire_s;
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = found_s ? BURST : IDLE;
      BURST:   state_s = (end_s || wd_fire_s) ? IDLE : BURST;
      default: state_s = IDLE;
    endcase
  end

  // State-decoded outputs; ready is forced low while rst is asserted so no beat is lost
  always_comb begin
    busy      = (state_r == BURST);
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == BURST) && space_ok_s && !rst) begin
      req_ready[grant_id] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Grant pointer, beat counter and registered FIFO write port
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= ID_W'(NUM_REQ - 1);
      beat_cnt_r <= {BEAT_W{1'b0}};
      fifo_wr    <= 1'b0;
      fifo_din   <= {DATA_W{1'b0}};
    end else begin
      fifo_wr <= acc_s;
      if (acc_s) begin
        fifo_din <= g_data_s;
      end
      if ((state_r == IDLE) && found_s) begin
        grant_id   <= winner_s;
        beat_cnt_r <= {BEAT_W{1'b0}};
      end else if (acc_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed self-checking bench for fifo_rr_wr_arbiter (default parameters).
`timescale 1ns/1ps
module tb_fifo_rr_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 5;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_din;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
`ifdef ARB_WATCHDOG_EN
  logic                      wd_flag;
`endif

  int errors = 0;
  int checks = 0;

  fifo_rr_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_count (fifo_count),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef ARB_WATCHDOG_EN
    ,
    .wd_flag    (wd_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] val);
    req_data[idx*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b0000; fifo_count = 5'd0;
    tick(); tick();
    chk("rst_wr", 32'(fifo_wr), 32'h0);
    chk("rst_din", 32'(fifo_din), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;

    // Single requester, 4 beats 0x10..0x13
    req_valid = 4'b0001; set_data(0, 8'h10);
    #1 chk("s1_idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk("s1_grant", 32'(grant_id), 32'h0);
    chk("s1_busy", 32'(busy), 32'h1);
    for (int b = 0; b < 4; b++) begin
      set_data(0, 8'(8'h10 + b));
      #1 chk("s1_ready", 32'(req_ready), 32'h1);
      tick();
      chk("s1_wr", 32'(fifo_wr), 32'h1);
      chk("s1_din", 32'(fifo_din), 32'(8'h10 + b));
    end
    chk("s1_end_busy", 32'(busy), 32'h0);
    req_valid = 4'b0000;
    tick();
    chk("s1_wr_off", 32'(fifo_wr), 32'h0);
    chk("s1_din_hold", 32'(fifo_din), 32'h13);

    // All requesters valid: grant order 0,1,2,3,0 with one gap cycle between bursts
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s2_grant", 32'(grant_id), 32'(k % 4));
      chk("s2_gap", 32'(fifo_wr), 32'h0);
      chk("s2_busy", 32'(busy), 32'h1);
      for (int b = 0; b < 4; b++) begin
        tick();
        chk("s2_wr", 32'(fifo_wr), 32'h1);
        chk("s2_din", 32'(fifo_din), 32'(8'hA0 + (k % 4)));
      end
    end
    chk("s2_end_busy", 32'(busy), 32'h0);
    req_valid = 4'b0000;
    tick();

    // Near-full FIFO throttling on requester 1
    req_valid = 4'b0010; set_data(1, 8'h55); fifo_count = 5'd15;
    tick();
    chk("s3_grant", 32'(grant_id), 32'h1);
    #1 chk("s3_ready15", 32'(req_ready), 32'h2);
    tick();
    chk("s3_wr1", 32'(fifo_wr), 32'h1);
    chk("s3_din1", 32'(fifo_din), 32'h55);
    set_data(1, 8'h56);
    #1 chk("s3_inflight", 32'(req_ready), 32'h0);
    tick();
    chk("s3_nowr", 32'(fifo_wr), 32'h0);
    chk("s3_din_hold", 32'(fifo_din), 32'h55);
    fifo_count = 5'd16;
    #1 chk("s3_full", 32'(req_ready), 32'h0);
    tick();
    chk("s3_full_nowr", 32'(fifo_wr), 32'h0);
    fifo_count = 5'd14;
    #1 chk("s3_reassert", 32'(req_ready), 32'h2);
    tick();
    chk("s3_wr2", 32'(fifo_wr), 32'h1);
    chk("s3_din2", 32'(fifo_din), 32'h56);
    fifo_count = 5'd15;
    #1 chk("s3_inflight2", 32'(req_ready), 32'h0);
    tick();
    chk("s3_nowr2", 32'(fifo_wr), 32'h0);
    fifo_count = 5'd0; set_data(1, 8'h57); req_last = 4'b0010;
    #1 chk("s3_ready0", 32'(req_ready), 32'h2);
    tick();
    chk("s3_wr3", 32'(fifo_wr), 32'h1);
    chk("s3_din3", 32'(fifo_din), 32'h57);
    chk("s3_last_busy", 32'(busy), 32'h0);
    req_valid = 4'b0000; req_last = 4'b0000;
    tick();
    chk("s3_idle_wr", 32'(fifo_wr), 32'h0);

    // Requester 2 ends early with last on its 2nd beat; requester 3 follows
    req_valid = 4'b1100; set_data(2, 8'h60); set_data(3, 8'h90);
    tick();
    chk("s4_grant2", 32'(grant_id), 32'h2);
    tick();
    chk("s4_din0", 32'(fifo_din), 32'h60);
    set_data(2, 8'h61); req_last = 4'b0100;
    tick();
    chk("s4_wr1", 32'(fifo_wr), 32'h1);
    chk("s4_din1", 32'(fifo_din), 32'h61);
    chk("s4_end", 32'(busy), 32'h0);
    req_valid = 4'b1000; req_last = 4'b0000;
    tick();
    chk("s4_grant3", 32'(grant_id), 32'h3);
    chk("s4_gap", 32'(fifo_wr), 32'h0);
    req_last = 4'b1000;
    tick();
    chk("s4_din3", 32'(fifo_din), 32'h90);
    chk("s4_end3", 32'(busy), 32'h0);
    req_valid = 4'b0000; req_last = 4'b0000;
    tick();

    // Reset during the 3rd beat of requester 0's burst
    req_valid = 4'b0001; set_data(0, 8'h70);
    tick();
    chk("s5_grant0", 32'(grant_id), 32'h0);
    tick();
    chk("s5_din0", 32'(fifo_din), 32'h70);
    set_data(0, 8'h71);
    tick();
    chk("s5_din1", 32'(fifo_din), 32'h71);
    set_data(0, 8'h72); rst = 1'b1;
    tick();
    chk("s5_rst_wr", 32'(fifo_wr), 32'h0);
    chk("s5_rst_busy", 32'(busy), 32'h0);
    chk("s5_rst_grant", 32'(grant_id), 32'h3);
    chk("s5_rst_din", 32'(fifo_din), 32'h0);
    rst = 1'b0; req_valid = 4'b0011;
    tick();
    chk("s5_after_grant", 32'(grant_id), 32'h0);
    chk("s5_after_busy", 32'(busy), 32'h1);

`ifdef ARB_WATCHDOG_EN
    // Requester 1 stalls after one beat; watchdog releases the grant after TIMEOUT cycles
    req_valid = 4'b0001; req_last = 4'b0001; set_data(0, 8'h80);
    tick();
    chk("wd_pre_end", 32'(busy), 32'h0);
    req_last = 4'b0000; req_valid = 4'b0010; set_data(1, 8'h81);
    tick();
    chk("wd_grant1", 32'(grant_id), 32'h1);
    chk("wd_flag0", 32'(wd_flag), 32'h0);
    tick();
    chk("wd_din", 32'(fifo_din), 32'h81);
    req_valid = 4'b0100; set_data(2, 8'h82);
    for (int s = 1; s < 8; s++) begin
      tick();
      chk("wd_hold_busy", 32'(busy), 32'h1);
      chk("wd_hold_flag", 32'(wd_flag), 32'h0);
    end
    tick();
    chk("wd_release", 32'(busy), 32'h0);
    chk("wd_flag1", 32'(wd_flag), 32'h1);
    tick();
    chk("wd_grant2", 32'(grant_id), 32'h2);
    chk("wd_sticky", 32'(wd_flag), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter that shares one 16-entry x 8-bit synchronous pixel FIFO among NUM_REQ pixel fetchers in the SAD full-search block-matching datapath. Typical fetchers are the current-block fetcher and the search-window row fetchers.
Grants one requester at a time for a burst of up to BURST_LEN pixels. Throttles on FIFO occupancy so the FIFO never receives a write while full. Drives the FIFO write port with registered wr/data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, pixel width
BURST_LEN, 4, max beats per grant (1..16)
FIFO_DEPTH, 16, FIFO capacity in entries
CNT_W, 5, width of fifo_count (must hold FIFO_DEPTH)
ID_W, 2, width of grant_id, equal to clog2(NUM_REQ)
TIMEOUT, 8, stall cycles before forced release (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester pixel valid
req_data  in  NUM_REQ*DATA_W  packed pixels; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  final pixel of requester's block, qualified by valid
req_ready  out  NUM_REQ  per-requester accept, combinational
fifo_count  in  CNT_W  current FIFO occupancy
fifo_wr  out  1  FIFO write strobe, registered
fifo_din  out  DATA_W  FIFO write data, registered
grant_id  out  ID_W  index of current or last granted requester
busy  out  1  high in state BURST

Behaviour:
- Reset values: state=IDLE, fifo_wr=0, fifo_din=0, grant_id=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0, busy=0, req_ready=0.
- Reset asserted mid-burst aborts the burst on the next edge. No write is issued in the reset cycle.
- States: IDLE and BURST.
- IDLE:
  - Scan requesters grant_id+1, grant_id+2, ... modulo NUM_REQ.
  - The first one with req_valid=1 is latched into grant_id. Go to BURST and clear beat_cnt.
  - No valid requester: stay in IDLE.
  - req_ready=0 in IDLE, so every grant has exactly one arbitration cycle.
- Space rule:
  - space_ok = (fifo_count + fifo_wr) < FIFO_DEPTH, computed at CNT_W+1 bits.
  - This accounts for the registered write in flight. FIFO reads are ignored, which is conservative.
- BURST:
  - req_ready[grant_id] = space_ok. All other ready bits are 0.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - On an accepted beat, next cycle has fifo_wr=1, fifo_din=req_data[g] (latency 1), and beat_cnt increments.
  - With no accepted beat, next cycle fifo_wr=0 and fifo_din holds its value.
- Burst end: the accepted beat has req_last=1, or beat_cnt==BURST_LEN-1. The next state is IDLE. grant_id keeps the winner, which sets the round-robin pointer.
- If the granted requester drops valid mid-burst, it keeps the grant indefinitely unless the optional feature is enabled.
- Full FIFO: when fifo_count==FIFO_DEPTH, or FIFO_DEPTH-1 with a write in flight, ready is held low until space frees. No beat is ever lost or duplicated.
- Throughput: at most one beat per cycle. Sustained rate is BURST_LEN/(BURST_LEN+1) with continuous requests and a draining FIFO.
- Non-granted requesters must hold their data stable while valid (standard valid/ready).

Optional Feature:
ARB_WATCHDOG_EN
- Defined:
  - In BURST, a stall counter increments each cycle req_valid[g]=0 and clears on any accepted beat.
  - The counter does not count cycles stalled by space_ok=0.
  - When it reaches TIMEOUT, the arbiter returns to IDLE, drops the grant and pulses sticky status bit wd_flag.
  - wd_flag is an extra output port, cleared only by rst.
- Undefined: no stall counter and no wd_flag port. A grant is held until last or BURST_LEN.

Test Plan:
- Reset then req_valid=4'b0001, 4 beats 0x10..0x13, fifo_count=0 -> grant_id=0 after 1 cycle; fifo_wr high 4 cycles with din 0x10..0x13 one cycle after each accept; back to IDLE.
- All 4 requesters valid continuously, BURST_LEN=4, FIFO drained -> grant order 0,1,2,3,0; each burst 4 writes separated by exactly 1 idle cycle.
- fifo_count=15, req 1 valid -> one beat accepted, then ready=0 while count=16; set count=14 -> ready reasserts; total writes equal accepted beats, no overflow.
- req 2 asserts req_last on its 2nd beat -> burst ends after 2 writes; next grant goes to 3 if valid, else 0.
- rst asserted in the 3rd beat of a burst -> next cycle fifo_wr=0, state IDLE, grant_id=NUM_REQ-1; after release requester 0 wins.
- ARB_WATCHDOG_EN, TIMEOUT=8: granted req 1 drops valid after 1 beat -> 8 stall cycles later grant released, wd_flag=1, req 2 then granted.
